multi_timer: RTL and testbench
==============================

# multi_timer

Memory-mapped, parametrised multi-channel timer that replaces the single-compare cycle timer on the processor's MMIO bus. A shared free-running cycle counter feeds NUM_CH independent compare channels. Each channel supports one-shot or periodic auto-reload operation, with per-channel pending bits and write-1-to-clear acknowledge. The block sits beside data memory, decodes its own address window, drives read data onto the shared bus through a tristate, and raises a single interrupt line to the CPU.

## Interface
- NUM_CH, 4: number of compare channels (1..8).
- WIDTH, 32: counter, compare and period width (8..32); bus data is zero-extended/truncated to WIDTH.
- BASE, 32'hffff0100: word-aligned base of the register window.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately while low.
- address  in  32  bus address.
- data  in  32  write data.
- MemRead  in  1  bus read strobe.
- MemWrite  in  1  bus write strobe.
- rdata  out  32  read data; tristated (Z) unless MemRead and a mapped register is addressed.
- TimerAddress  out  1  high when address hits any mapped register (combinational).
- TimerInterrupt  out  1  OR of all pending bits.
- irq_vec  out  NUM_CH  per-channel pending bits.

## Operation
- Register map (offsets from BASE):
  - 0x00 COUNT: R = counter; W loads counter.
  - 0x04 STATUS: R = pending[NUM_CH-1:0]; W = write-1-to-clear.
  - 0x08 ENABLE: R/W enable[NUM_CH-1:0].
  - 0x10+8*ch CMP[ch]: R/W.
  - 0x14+8*ch PER[ch]: R/W.
- Offsets beyond the last channel, and unaligned addresses: TimerAddress=0, writes ignored, rdata=Z.
- Counter increments by 1 every cycle and wraps from 2^WIDTH-1 to 0.
- Match for channel ch: enable[ch] and counter==CMP[ch] (registered values). On a match:
  - pending[ch] is set.
  - If PER[ch]!=0: CMP[ch] <= CMP[ch]+PER[ch] mod 2^WIDTH (periodic).
  - If PER[ch]==0: enable[ch] auto-clears (one-shot).
- A disabled channel never sets pending; its existing pending bit is retained.
- Reset values: counter 0, CMP all ones, PER 0, ENABLE 0, pending 0. Therefore TimerInterrupt=0, irq_vec=0, and rdata=Z.

## Timing
- Writes take effect at the clock edge on which MemWrite is sampled with a hit.
- Reads are combinational from current register state; zero latency.
- Pending rises at the edge ending the cycle in which counter==CMP. TimerInterrupt and irq_vec are high from the next cycle (one-cycle latency).
- COUNT write: the counter takes the written value at that edge; no increment in that cycle. A match in that same cycle is evaluated on the pre-write counter.
- Simultaneous events:
  - Match and STATUS W1C of the same bit: set wins, so pending stays 1.
  - Match and CMP[ch] write: the written value wins, no reload add; pending is still set.
  - Match and ENABLE write: the written value wins over the one-shot auto-clear.
  - Match and PER[ch] write: the reload uses the old PER.
- Reload wrap-around: CMP 0xFFFFFFF0 + PER 0x20 gives 0x00000010; the match fires after the counter wraps.
- Reset asserted mid-operation: all state clears asynchronously. The first increment occurs on the first rising edge after release.

## Structure
- Shared package/header timer_pkg holds the register offsets (OFS_COUNT, OFS_STATUS, OFS_ENABLE, OFS_CMP0, OFS_PER0, CH_STRIDE=8) and the reset constants (CMP_RESET = all ones).
- One natural sub-module, timer_channel, instantiated NUM_CH times. Each instance holds CMP, PER, enable and pending plus the match/reload logic. Inputs: counter, write strobes, write data, W1C bit.
- The top level holds the counter, the address decode, the read mux and the tristate.

## Test plan
- Reset then idle 100 cycles with all channels disabled -> TimerInterrupt=0 throughout; COUNT read at cycle 100 returns 100 ±1 (bus read cycle).
- One-shot: write CMP0=50, ENABLE=0x1 -> irq_vec[0] rises the cycle after counter==50; ENABLE reads 0x0; no second interrupt after counter wraps (WIDTH=8 build).
- Periodic: CMP1=20, PER1=10, ENABLE=0x2 -> pending[1] sets at counts 20, 30, 40. Each W1C 0x2 write clears it until the next match; W1C coinciding with the match at 30 leaves pending=1.
- Wrap: WIDTH=8, CMP2=0xF0, PER2=0x20 -> matches at 0xF0, then CMP2=0x10, and the match occurs post-wrap at counter 0x10.
- Collisions: write COUNT=0x100 in the cycle counter==CMP3 -> pending[3] set, counter=0x100. Write CMP3 on a match cycle -> the written value is kept, no reload add.
- Bus behaviour: reads at BASE+0x0C and BASE+0x10+8*NUM_CH -> TimerAddress=0, rdata=Z. Assert reset low mid-run -> all outputs 0/Z immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Register map and reset constants shared by the multi-channel MMIO timer.
package timer_pkg;
  localparam logic [31:0] OFS_COUNT  = 32'h00;
  localparam logic [31:0] OFS_STATUS = 32'h04;
  localparam logic [31:0] OFS_ENABLE = 32'h08;
  localparam logic [31:0] OFS_CMP0   = 32'h10;
  localparam logic [31:0] OFS_PER0   = 32'h14;
  localparam logic [31:0] CH_STRIDE  = 32'h08;
  localparam logic [31:0] CMP_RESET  = 32'hffff_ffff;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_COUNT, SEL_STATUS, SEL_ENABLE, SEL_CMP, SEL_PER
  } reg_sel_t;
endpackage

// File: rtl/timer_channel.sv
// One compare channel: CMP/PER/enable/pending with one-shot or periodic reload.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_cmp_we,
  input  logic             i_per_we,
  input  logic             i_en_we,
  input  logic             i_en_wdata,
  input  logic             i_w1c,
  output logic [WIDTH-1:0] o_cmp,
  output logic [WIDTH-1:0] o_per,
  output logic             o_en,
  output logic             o_pend
);
  logic [WIDTH-1:0] r_cmp, r_per;
  logic             r_en, r_pend;
  logic             w_match, w_periodic;

  assign w_match    = r_en && (i_count == r_cmp);
  assign w_periodic = |r_per;

  // Bus writes take priority over the match side effects; pending set beats W1C.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cmp  <= CMP_RESET[WIDTH-1:0];
      r_per  <= '0;
      r_en   <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (i_cmp_we)                    r_cmp <= i_wdata;
      else if (w_match && w_periodic)  r_cmp <= r_cmp + r_per;
      if (i_per_we)                    r_per <= i_wdata;
      if (i_en_we)                     r_en  <= i_en_wdata;
      else if (w_match && !w_periodic) r_en  <= 1'b0;
      if (w_match)                     r_pend <= 1'b1;
      else if (i_w1c)                  r_pend <= 1'b0;
    end
  end

  assign o_cmp  = r_cmp;
  assign o_per  = r_per;
  assign o_en   = r_en;
  assign o_pend = r_pend;
endmodule

// File: rtl/multi_timer.sv
// MMIO multi-channel timer: shared free-running counter, address decode,
// tristated read mux and NUM_CH compare channels.
module multi_timer
  import timer_pkg::*;
#(
  parameter int          NUM_CH = 4,
  parameter int          WIDTH  = 32,
  parameter logic [31:0] BASE   = 32'hffff0100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic [31:0]       data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output wire  [31:0]       rdata,
  output logic              TimerAddress,
  output logic              TimerInterrupt,
  output logic [NUM_CH-1:0] irq_vec
);
  localparam logic [31:0] CH_SPAN = CH_STRIDE * 32'(NUM_CH);

  logic [WIDTH-1:0]              r_count;
  logic [WIDTH-1:0]              w_wdata;
  logic [31:0]                   w_ofs, w_rel, w_rd;
  logic [2:0]                    w_ch;
  reg_sel_t                      w_sel;
  logic                          w_wr;
  logic [NUM_CH-1:0][WIDTH-1:0]  w_cmp, w_per;
  logic [NUM_CH-1:0]             w_en, w_pend;
  logic [NUM_CH-1:0]             w_cmp_we, w_per_we, w_w1c;

  assign w_wdata = data[WIDTH-1:0];

  // Out-of-window addresses wrap w_rel to a huge value and fall through to SEL_NONE.
  always_comb begin
    w_ofs = address - BASE;
    w_rel = w_ofs - OFS_CMP0;
    w_ch  = w_rel[5:3];
    w_sel = SEL_NONE;
    if (w_ofs == OFS_COUNT)       w_sel = SEL_COUNT;
    else if (w_ofs == OFS_STATUS) w_sel = SEL_STATUS;
    else if (w_ofs == OFS_ENABLE) w_sel = SEL_ENABLE;
    else if (w_rel < CH_SPAN && w_rel[1:0] == 2'b00)
      w_sel = (w_rel[2:0] == 3'(OFS_PER0 - OFS_CMP0)) ? SEL_PER : SEL_CMP;
  end

  assign TimerAddress = (w_sel != SEL_NONE);
  assign w_wr         = MemWrite && TimerAddress;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          r_count <= '0;
    else if (w_wr && w_sel == SEL_COUNT) r_count <= w_wdata;
    else                                 r_count <= r_count + WIDTH'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_cmp_we[g] = w_wr && (w_sel == SEL_CMP) && (w_ch == 3'(g));
    assign w_per_we[g] = w_wr && (w_sel == SEL_PER) && (w_ch == 3'(g));
    assign w_w1c[g]    = w_wr && (w_sel == SEL_STATUS) && data[g];

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clock      (clock),
      .reset      (reset),
      .i_count    (r_count),
      .i_wdata    (w_wdata),
      .i_cmp_we   (w_cmp_we[g]),
      .i_per_we   (w_per_we[g]),
      .i_en_we    (w_wr && (w_sel == SEL_ENABLE)),
      .i_en_wdata (data[g]),
      .i_w1c      (w_w1c[g]),
      .o_cmp      (w_cmp[g]),
      .o_per      (w_per[g]),
      .o_en       (w_en[g]),
      .o_pend     (w_pend[g])
    );
  end

  always_comb begin
    w_rd = '0;
    case (w_sel)
      SEL_COUNT:  w_rd[WIDTH-1:0]  = r_count;
      SEL_STATUS: w_rd[NUM_CH-1:0] = w_pend;
      SEL_ENABLE: w_rd[NUM_CH-1:0] = w_en;
      SEL_CMP, SEL_PER:
        for (int i = 0; i < NUM_CH; i++)
          if (w_ch == 3'(i)) w_rd[WIDTH-1:0] = (w_sel == SEL_CMP) ? w_cmp[i] : w_per[i];
      default: ;
    endcase
  end

  assign rdata          = (MemRead && TimerAddress) ? w_rd : 'z;
  assign irq_vec        = w_pend;
  assign TimerInterrupt = |w_pend;
endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer (WIDTH=8 build): reset/decode table, directed corner
// sequences, then random bus traffic against an arithmetic reference model.
module tb_multi_timer;
  localparam int          NCH  = 4;
  localparam int          W    = 8;
  localparam int          MOD  = 256;
  localparam logic [31:0] BASE = 32'hffff0100;
  localparam logic [31:0] ZBUS = 32'hffff_ffff;  // undriven bus reads as all ones via tri1

  logic              clock = 0, reset = 0;
  logic [31:0]       address = 0, data = 0;
  logic              MemRead = 0, MemWrite = 0;
  tri1  [31:0]       rdata;
  logic              TimerAddress, TimerInterrupt;
  logic [NCH-1:0]    irq_vec;

  int n_chk = 0, n_fail = 0;

  int m_cnt;
  int m_cmp[NCH], m_per[NCH];
  bit m_en[NCH], m_pend[NCH];

  multi_timer #(.NUM_CH(NCH), .WIDTH(W), .BASE(BASE)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data),
    .MemRead(MemRead), .MemWrite(MemWrite), .rdata(rdata),
    .TimerAddress(TimerAddress), .TimerInterrupt(TimerInterrupt), .irq_vec(irq_vec)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 none, 1 count, 2 status, 3 enable, 4 cmp, 5 per
  function automatic int kind_of(input logic [31:0] addr, output int ch);
    longint ofs;
    ofs = longint'(addr - BASE);
    ch = 0;
    if (ofs == 0) return 1;
    if (ofs == 4) return 2;
    if (ofs == 8) return 3;
    if (ofs >= 16 && ofs < 16 + 8 * NCH && ofs % 4 == 0) begin
      ch = int'((ofs - 16) / 8);
      return ((ofs - 16) % 8 == 0) ? 4 : 5;
    end
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input int k, input int ch);
    int v = 0;
    case (k)
      1: v = m_cnt;
      2: for (int i = 0; i < NCH; i++) if (m_pend[i]) v += (1 << i);
      3: for (int i = 0; i < NCH; i++) if (m_en[i]) v += (1 << i);
      4: v = m_cmp[ch];
      5: v = m_per[ch];
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      m_cmp[i] = MOD - 1; m_per[i] = 0; m_en[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_step(input logic wr, input logic [31:0] addr, input logic [31:0] d);
    int k, ch, dv;
    bit match[NCH];
    int ncmp[NCH];
    bit nen[NCH];
    k  = wr ? kind_of(addr, ch) : 0;
    dv = int'(d % MOD);
    for (int i = 0; i < NCH; i++) begin
      match[i] = m_en[i] && (m_cnt == m_cmp[i]);
      ncmp[i]  = m_cmp[i];
      nen[i]   = m_en[i];
      if (match[i]) begin
        if (m_per[i] != 0) ncmp[i] = (m_cmp[i] + m_per[i]) % MOD;
        else               nen[i]  = 0;
      end
    end
    if (k == 3) for (int i = 0; i < NCH; i++) nen[i] = d[i];
    if (k == 2) for (int i = 0; i < NCH; i++) if (d[i]) m_pend[i] = 0;
    for (int i = 0; i < NCH; i++) if (match[i]) m_pend[i] = 1;
    if (k == 4) ncmp[ch] = dv;
    if (k == 5) m_per[ch] = dv;
    m_cnt = (k == 1) ? dv : (m_cnt + 1) % MOD;
    for (int i = 0; i < NCH; i++) begin
      m_cmp[i] = ncmp[i]; m_en[i] = nen[i];
    end
  endtask

  // One bus cycle: drive, sample mid-cycle against the model, advance on the edge.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                     output logic [31:0] rv, output logic ta);
    int k, ch;
    address = a; data = d; MemRead = rd; MemWrite = wr;
    @(negedge clock);
    k = kind_of(a, ch);
    check("irq_vec", 32'(irq_vec), model_read(2, 0));
    check("TimerInterrupt", 32'(TimerInterrupt), 32'(model_read(2, 0) != 0));
    check("TimerAddress", 32'(TimerAddress), 32'(k != 0));
    check("rdata", rdata, (rd && k != 0) ? model_read(k, ch) : ZBUS);
    rv = rdata; ta = TimerAddress;
    @(posedge clock);
    model_step(wr, a, d);
    #1;
    address = '0; data = '0; MemRead = 0; MemWrite = 0;
  endtask

  task automatic wr(input logic [31:0] ofs, input logic [31:0] d);
    logic [31:0] rv; logic ta;
    bus(BASE + ofs, d, 1'b0, 1'b1, rv, ta);
  endtask

  task automatic rd(input logic [31:0] ofs, output logic [31:0] rv);
    logic ta;
    bus(BASE + ofs, 32'h0, 1'b1, 1'b0, rv, ta);
  endtask

  task automatic idle();
    logic [31:0] rv; logic ta;
    bus(32'h0, 32'h0, 1'b0, 1'b0, rv, ta);
  endtask

  task automatic wait_cnt(input int target);
    int guard = 0;
    while (m_cnt != target && guard < 600) begin idle(); guard++; end
    if (m_cnt != target) begin
      n_chk++; n_fail++;
      $display("FAIL wait_cnt timeout: counter %0d required %0d", m_cnt, target);
    end
  endtask

  typedef struct {
    logic [31:0] ofs;
    logic        hit;
    logic [31:0] rd;
  } vec_t;

  initial begin
    vec_t        tbl[10];
    logic [31:0] rv;
    logic        ta;

    tbl[0] = '{32'h04, 1'b1, 32'h0};
    tbl[1] = '{32'h08, 1'b1, 32'h0};
    tbl[2] = '{32'h10, 1'b1, 32'hff};
    tbl[3] = '{32'h14, 1'b1, 32'h0};
    tbl[4] = '{32'h28, 1'b1, 32'hff};
    tbl[5] = '{32'h2c, 1'b1, 32'h0};
    tbl[6] = '{32'h0c, 1'b0, ZBUS};
    tbl[7] = '{32'h30, 1'b0, ZBUS};
    tbl[8] = '{32'h12, 1'b0, ZBUS};
    tbl[9] = '{32'hfffffffc, 1'b0, ZBUS};

    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1;
    check("reset irq_vec", 32'(irq_vec), 32'h0);
    check("reset TimerInterrupt", 32'(TimerInterrupt), 32'h0);
    check("reset rdata", rdata, ZBUS);

    // Idle with everything disabled, then sample COUNT.
    repeat (100) idle();
    rd(32'h0, rv);
    n_chk++;
    if (rv < 99 || rv > 101) begin
      n_fail++;
      $display("FAIL count after 100 idle: got %0d expected 100+-1", rv);
    end

    // Reset-state register values and decode holes.
    foreach (tbl[i]) begin
      bus(BASE + tbl[i].ofs, 32'h0, 1'b1, 1'b0, rv, ta);
      check($sformatf("tbl[%0d] hit", i), 32'(ta), 32'(tbl[i].hit));
      check($sformatf("tbl[%0d] data", i), rv, tbl[i].rd);
    end

    // One-shot on channel 0.
    wr(32'h00, 40); wr(32'h10, 50); wr(32'h08, 32'h1);
    wait_cnt(50);
    check("oneshot before", 32'(irq_vec[0]), 32'h0);
    idle();
    check("oneshot irq_vec", 32'(irq_vec[0]), 32'h1);
    check("oneshot TimerInterrupt", 32'(TimerInterrupt), 32'h1);
    rd(32'h08, rv);
    check("oneshot enable cleared", rv, 32'h0);
    wr(32'h04, 32'h1);
    repeat (300) idle();
    check("oneshot no refire", 32'(irq_vec[0]), 32'h0);

    // Periodic on channel 1, with W1C colliding with the match at 30.
    wr(32'h00, 10); wr(32'h18, 20); wr(32'h1c, 10); wr(32'h08, 32'h2);
    wait_cnt(20); idle();
    check("periodic @20", 32'(irq_vec[1]), 32'h1);
    wr(32'h04, 32'h2);
    check("periodic w1c", 32'(irq_vec[1]), 32'h0);
    wait_cnt(30); wr(32'h04, 32'h2);
    check("periodic set beats w1c", 32'(irq_vec[1]), 32'h1);
    wr(32'h04, 32'h2);
    check("periodic w1c 2", 32'(irq_vec[1]), 32'h0);
    wait_cnt(40); idle();
    check("periodic @40", 32'(irq_vec[1]), 32'h1);
    rd(32'h18, rv);
    check("periodic cmp1", rv, 32'd50);

    // Reload that wraps past 2^WIDTH on channel 2.
    wr(32'h04, 32'hf); wr(32'h08, 32'h0);
    wr(32'h00, 32'he0); wr(32'h20, 32'hf0); wr(32'h24, 32'h20); wr(32'h08, 32'h4);
    wait_cnt(32'hf0); idle();
    check("wrap first match", 32'(irq_vec[2]), 32'h1);
    rd(32'h20, rv);
    check("wrap cmp2 reload", rv, 32'h10);
    wr(32'h04, 32'h4);
    wait_cnt(32'h10);
    check("wrap before post-wrap match", 32'(irq_vec[2]), 32'h0);
    idle();
    check("wrap post-wrap match", 32'(irq_vec[2]), 32'h1);

    // Channel 3 collisions: COUNT write, CMP write, ENABLE write on match cycles.
    wr(32'h04, 32'hf); wr(32'h08, 32'h0);
    wr(32'h28, 32'h80); wr(32'h2c, 32'h0); wr(32'h00, 32'h70); wr(32'h08, 32'h8);
    wait_cnt(32'h80);
    wr(32'h00, 32'h1a5);
    check("count collision pend", 32'(irq_vec[3]), 32'h1);
    rd(32'h00, rv);
    check("count collision value", rv, 32'ha5);
    rd(32'h08, rv);
    check("count collision oneshot", rv, 32'h0);
    wr(32'h2c, 5); wr(32'h28, 32'hc0); wr(32'h04, 32'h8); wr(32'h08, 32'h8);
    wait_cnt(32'hc0);
    wr(32'h28, 32'h33);
    check("cmp collision pend", 32'(irq_vec[3]), 32'h1);
    rd(32'h28, rv);
    check("cmp collision value", rv, 32'h33);
    wr(32'h2c, 0); wr(32'h04, 32'h8);
    wait_cnt(32'h33);
    wr(32'h08, 32'h8);
    check("enable collision pend", 32'(irq_vec[3]), 32'h1);
    rd(32'h08, rv);
    check("enable collision kept", rv, 32'h8);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ofs, d;
      int sel;
      sel = $urandom_range(0, 15);
      case (sel)
        0:       ofs = 32'h00;
        1, 2:    ofs = 32'h04;
        3, 4:    ofs = 32'h08;
        5:       ofs = 32'h0c;
        6:       ofs = 32'h30;
        7:       ofs = 32'h02;
        default: ofs = 32'h10 + 32'($urandom_range(0, 7)) * 4;
      endcase
      d = (ofs[2] && ofs >= 32'h10) ? 32'($urandom_range(0, 40)) : $urandom;
      bus(BASE + ofs, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 2), rv, ta);
    end

    // Asynchronous reset in mid-cycle with a pending interrupt.
    wr(32'h04, 32'hf); wr(32'h08, 32'h0);
    wr(32'h00, 32'h10); wr(32'h10, 32'h14); wr(32'h14, 32'h0); wr(32'h08, 32'h1);
    wait_cnt(32'h14); idle();
    check("pre-reset pend", 32'(irq_vec[0]), 32'h1);
    #3 reset = 0;
    #1;
    check("async reset irq_vec", 32'(irq_vec), 32'h0);
    check("async reset TimerInterrupt", 32'(TimerInterrupt), 32'h0);
    check("async reset rdata", rdata, ZBUS);
    address = BASE; MemRead = 1;
    #1;
    check("async reset count", rdata, 32'h0);
    MemRead = 0;
    @(posedge clock);
    #1 reset = 1;
    model_reset();
    rd(32'h00, rv);
    check("post-reset count 0", rv, 32'h0);
    rd(32'h00, rv);
    check("post-reset count 1", rv, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
